reg_trace_streamer: RTL and testbench

- Passive tap on the datapath's register-file write port. Keeps a shadow copy of all architectural registers and streams write records (line, register index, value) through a buffered valid/ready interface.
- Generalised successor to the fixed 32-register debug view: register count, data width and buffer depth are parameters. Adds change-only filtering, on-demand full snapshots, and a drop counter.
- Sits beside the register file. Feeds a trace sink or bench scoreboard in place of 32 parallel register buses.

---
 rtl/reg_trace_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 54 +++++
 rtl/reg_trace_streamer.sv | 137 +++++++++++++
 tb/tb_reg_trace_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_trace_pkg.sv
// Shared types for the register trace streamer.
// FSM states, record kinds and record width helper.
package reg_trace_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SNAP = 1'b1
  } state_t;

  localparam logic KIND_LIVE = 1'b0;
  localparam logic KIND_SNAP = 1'b1;

  // Packed record layout: {kind, line, addr, data}
  function automatic int entryW(
    input int lineW,
    input int addrW,
    input int dataW
  );
    return 1 + lineW + addrW + dataW;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with occupancy output.
// Ports: push/pushData in, pop in, headData/notEmpty/full/level out.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             pushData,
  input  logic                     pop,
  output logic [W-1:0]             headData,
  output logic                     notEmpty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [LW-1:0] CONE = LW'(1);
  localparam logic [LW-1:0] FULLV = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [LW-1:0] count;

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PONE;
      if (pop)  rdPtr <= rdPtr + PONE;
      unique case (1'b1)
        push && !pop: count <= count + CONE;
        pop && !push: count <= count - CONE;
        default: ;
      endcase
    end
  end

  assign headData = mem[rdPtr];
  assign notEmpty = count != '0;
  assign full     = count == FULLV;
  assign level    = count;

endmodule

// File: rtl/reg_trace_streamer.sv
// Register-file write tap: shadow copy, change filter, snapshot FSM.
// Ports: write tap in, snap_req in, trace_* valid/ready stream out, status out.
module reg_trace_streamer
  import reg_trace_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int LINE_W   = 32,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        mode_all,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic [LINE_W-1:0]           line,
  input  logic                        snap_req,
  output logic                        trace_valid,
  input  logic                        trace_ready,
  output logic                        trace_kind,
  output logic [LINE_W-1:0]           trace_line,
  output logic [$clog2(NUM_REGS)-1:0] trace_addr,
  output logic [XLEN-1:0]             trace_data,
  output logic                        snap_busy,
  output logic                        snap_done,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [CNT_W-1:0]            drop_count
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int EW = entryW(LINE_W, AW, XLEN);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] IONE = AW'(1);
  localparam logic [CNT_W-1:0] DONE1 = CNT_W'(1);

  logic [XLEN-1:0] shadow [NUM_REGS];
  state_t          state;
  state_t          nextState;
  logic [AW-1:0]   idx;
  logic            snapDone;
  logic [CNT_W-1:0] dropCnt;

  logic          wrHit;
  logic          liveEvt;
  logic          headValid;
  logic          full;
  logic          pop;
  logic          canPush;
  logic          snapPush;
  logic          livePush;
  logic          drop;
  logic          push;
  logic [EW-1:0] pushData;
  logic [EW-1:0] headData;

  assign wrHit   = wr_en && (wr_addr != '0);
  // Filter compares against the value before this edge's update
  assign liveEvt = wrHit && enable &&
                   (mode_all || (wr_data != shadow[wr_addr]));
  assign pop     = headValid && trace_ready;
  assign canPush = !full || pop;
  assign livePush = liveEvt && canPush;
  assign drop    = liveEvt && !canPush;
  assign push    = livePush || snapPush;

  always_comb begin
    nextState = state;
    snapPush  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (snap_req) nextState = ST_SNAP;
      end
      ST_SNAP: begin
        // Live traffic wins; snapshot just stalls a cycle
        snapPush = !liveEvt && canPush;
        if (snapPush && idx == LAST) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    pushData = '0;
    if (liveEvt) pushData = {KIND_LIVE, line, wr_addr, wr_data};
    else         pushData = {KIND_SNAP, line, idx, shadow[idx]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      snapDone <= 1'b0;
      dropCnt  <= '0;
    end else begin
      state    <= nextState;
      snapDone <= snapPush && (idx == LAST);
      if (state == ST_IDLE) idx <= '0;
      else if (snapPush)    idx <= idx + IONE;
      if (drop && dropCnt != '1) dropCnt <= dropCnt + DONE1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (wrHit) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) uFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .headData (headData),
    .notEmpty (headValid),
    .full     (full),
    .level    (fifo_level)
  );

  // Head fields read as zero while empty so reset clears every output
  assign {trace_kind, trace_line, trace_addr, trace_data} =
    headValid ? headData : '0;
  assign trace_valid = headValid;
  assign snap_busy   = state == ST_SNAP;
  assign snap_done   = snapDone;
  assign drop_count  = dropCnt;

endmodule

// File: tb/tb_reg_trace_streamer.sv
// Scoreboard bench for reg_trace_streamer.
// Directed test-plan cases followed by randomized traffic.
module tb_reg_trace_streamer;

  localparam int XLEN   = 32;
  localparam int NR     = 32;
  localparam int LINE_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int AW     = 5;
  localparam int LW     = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic mode_all = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [XLEN-1:0] wr_data = '0;
  logic [LINE_W-1:0] line = '0;
  logic snap_req = 1'b0;
  logic trace_ready = 1'b0;

  logic trace_valid;
  logic trace_kind;
  logic [LINE_W-1:0] trace_line;
  logic [AW-1:0] trace_addr;
  logic [XLEN-1:0] trace_data;
  logic snap_busy;
  logic snap_done;
  logic [LW-1:0] fifo_level;
  logic [CNT_W-1:0] drop_count;

  always #5 clock = ~clock;

  reg_trace_streamer dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mode_all    (mode_all),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .line        (line),
    .snap_req    (snap_req),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_kind  (trace_kind),
    .trace_line  (trace_line),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .snap_busy   (snap_busy),
    .snap_done   (snap_done),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count)
  );

  typedef struct {
    logic             kind;
    logic [LINE_W-1:0] ln;
    logic [AW-1:0]    addr;
    logic [XLEN-1:0]  data;
  } rec_t;

  rec_t expQ[$];
  logic [XLEN-1:0] mShadow [NR];
  int mLevel = 0;
  int mDrop = 0;
  bit mSnap = 0;
  bit mDone = 0;
  int mIdx = 0;

  int nCmp = 0;
  int nFail = 0;
  int popCnt = 0;
  int snapPopCnt = 0;
  int doneCnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: ordered record stream with a bounded buffer
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      expQ.delete();
      mLevel = 0;
      mDrop = 0;
      mSnap = 0;
      mDone = 0;
      mIdx = 0;
      foreach (mShadow[i]) mShadow[i] = '0;
    end else begin
      bit pop, acc, live, startSnap;
      rec_t r;
      pop = (mLevel > 0) && trace_ready;
      acc = (mLevel < DEPTH) || pop;
      live = wr_en && (wr_addr != 0) && enable &&
             (mode_all || (wr_data != mShadow[wr_addr]));
      startSnap = !mSnap && snap_req;
      mDone = 0;
      if (live) begin
        if (acc) begin
          r.kind = 1'b0;
          r.ln = line;
          r.addr = wr_addr;
          r.data = wr_data;
          expQ.push_back(r);
          mLevel++;
        end else if (mDrop < (1 << CNT_W) - 1) begin
          mDrop++;
        end
      end else if (mSnap && acc) begin
        r.kind = 1'b1;
        r.ln = line;
        r.addr = AW'(mIdx);
        r.data = mShadow[mIdx];
        expQ.push_back(r);
        mLevel++;
        if (mIdx == NR - 1) begin
          mSnap = 0;
          mDone = 1;
          mIdx = 0;
        end else begin
          mIdx++;
        end
      end
      if (pop) mLevel--;
      if (startSnap) begin
        mSnap = 1;
        mIdx = 0;
      end
      if (wr_en && wr_addr != 0) mShadow[wr_addr] = wr_data;
    end
  end

  // Monitor: compare head and status away from the active edge
  always @(negedge clock) begin
    chk("valid", 64'(trace_valid), 64'(expQ.size() != 0));
    chk("level", 64'(fifo_level), 64'(mLevel));
    chk("drop", 64'(drop_count), 64'(mDrop));
    chk("busy", 64'(snap_busy), 64'(mSnap));
    chk("done", 64'(snap_done), 64'(mDone));
    if (snap_done) doneCnt++;
    if (trace_valid && expQ.size() > 0) begin
      chk("kind", 64'(trace_kind), 64'(expQ[0].kind));
      chk("line", 64'(trace_line), 64'(expQ[0].ln));
      chk("addr", 64'(trace_addr), 64'(expQ[0].addr));
      chk("data", 64'(trace_data), 64'(expQ[0].data));
      if (trace_ready) begin
        if (expQ[0].kind) snapPopCnt++;
        popCnt++;
        expQ.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input int d, input int ln);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = XLEN'(d);
    line = LINE_W'(ln);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic waitIdle(input string nm);
    int b;
    b = 0;
    while ((snap_busy || trace_valid) && b < 500) begin
      tick();
      b++;
    end
    chk(nm, 64'(b < 500), 64'(1));
  endtask

  task automatic chkOuts0(input string nm);
    chk({nm, "_ctl"}, 64'({trace_valid, trace_kind, snap_busy, snap_done}), 64'(0));
    chk({nm, "_lvl"}, 64'(fifo_level), 64'(0));
    chk({nm, "_drop"}, 64'(drop_count), 64'(0));
    chk({nm, "_line"}, 64'(trace_line), 64'(0));
    chk({nm, "_addr"}, 64'(trace_addr), 64'(0));
    chk({nm, "_data"}, 64'(trace_data), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    int p0, d0, b;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chkOuts0("rst");
    reset = 1'b1;
    tick();
    enable = 1'b1;
    trace_ready = 1'b1;

    // change filter and record-all mode
    p0 = popCnt;
    wr(5, 7, 3);
    idle(3);
    chk("rec_first", 64'(popCnt - p0), 64'(1));
    p0 = popCnt;
    wr(5, 7, 4);
    idle(3);
    chk("rec_same", 64'(popCnt - p0), 64'(0));
    mode_all = 1'b1;
    p0 = popCnt;
    wr(5, 7, 5);
    idle(3);
    chk("rec_all", 64'(popCnt - p0), 64'(1));
    mode_all = 1'b0;

    // index 0 ignored
    p0 = popCnt;
    wr(0, 99, 6);
    idle(3);
    chk("rec_x0", 64'(popCnt - p0), 64'(0));

    // fill and overflow
    trace_ready = 1'b0;
    for (int i = 1; i <= 17; i++) wr(i, 1000 + i, 100 + i);
    chk("lvl_full", 64'(fifo_level), 64'(16));
    chk("drop_one", 64'(drop_count), 64'(1));
    trace_ready = 1'b1;
    wr(20, 2000, 200);
    chk("lvl_pushpop", 64'(fifo_level), 64'(16));
    chk("drop_still", 64'(drop_count), 64'(1));
    waitIdle("drain1");

    // full snapshot
    for (int i = 1; i < NR; i++) wr(i, i, 300 + i);
    waitIdle("drain2");
    p0 = snapPopCnt;
    d0 = doneCnt;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    waitIdle("snap_end");
    chk("snap_count", 64'(snapPopCnt - p0), 64'(32));
    chk("snap_done1", 64'(doneCnt - d0), 64'(1));
    chk("busy_low", 64'(snap_busy), 64'(0));

    // live write collides with snapshot at idx 10
    p0 = popCnt;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    idle(10);
    wr(10, 500, 777);
    waitIdle("snap2_end");
    chk("snap_live33", 64'(popCnt - p0), 64'(33));

    // randomized traffic
    repeat (2000) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, NR - 1));
      wr_data = XLEN'($urandom_range(0, 3));
      line = LINE_W'($urandom);
      enable = $urandom_range(0, 7) != 0;
      mode_all = 1'($urandom_range(0, 1));
      snap_req = $urandom_range(0, 40) == 0;
      trace_ready = $urandom_range(0, 99) < 60;
      tick();
    end
    wr_en = 1'b0;
    snap_req = 1'b0;
    enable = 1'b1;
    mode_all = 1'b0;
    trace_ready = 1'b1;
    waitIdle("rand_drain");

    // reset in the middle of a snapshot with entries queued
    p0 = snapPopCnt;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    b = 0;
    while (snapPopCnt - p0 < 7 && b < 100) begin
      tick();
      b++;
    end
    trace_ready = 1'b0;
    while (fifo_level != 5 && b < 100) begin
      tick();
      b++;
    end
    chk("reach5", 64'(b < 100), 64'(1));
    #2 reset = 1'b0;
    #1;
    chkOuts0("rst_mid");
    tick();
    reset = 1'b1;
    tick();
    trace_ready = 1'b1;
    p0 = snapPopCnt;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    waitIdle("snap3_end");
    chk("snap_restart", 64'(snapPopCnt - p0), 64'(32));

    chk("sb_empty", 64'(expQ.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
